// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter:
// state encoding, default widths and counter sizing.
package dmem_arbiter_pkg;

   localparam int ADDR_W_DEF     = 8;
   localparam int DATA_W_DEF     = 8;
   localparam int STARVE_LIM_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   // Bits needed to hold 0..lim inclusive.
   function automatic int cnt_width(input int lim);
      return (lim < 1) ? 1 : $clog2(lim + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select for the arbiter: port 0 first unless port 1 has
// been passed over STARVE_LIM times in a row; also next starve count.
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int STARVE_LIM = STARVE_LIM_DEF,
   parameter int CNT_W      = cnt_width(STARVE_LIM_DEF)
)(
   input  logic             p0_req_i,
   input  logic             p1_req_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic             any_o,
   output logic             win1_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

   logic win1;

   // Port 1 wins when alone, or when its starvation limit is reached.
   always_comb begin
      win1   = p1_req_i & (~p0_req_i | (cnt_i == LIM));
      any_o  = p0_req_i | p1_req_i;
      win1_o = win1;
      cnt_o  = cnt_i;
      if (win1 || !p1_req_i) begin
         cnt_o = '0;
      end else if (p0_req_i && cnt_i != LIM) begin
         cnt_o = cnt_i + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE/ISSUE/RESP sequencer with
// registered grants, memory strobes and per-port read data.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_LIM = STARVE_LIM_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = cnt_width(STARVE_LIM);

   arb_state_e        state_q;
   logic [CNT_W-1:0]  starve_q;
   logic [CNT_W-1:0]  starve_d;
   logic              any_d;
   logic              win1_d;
   logic              win1_q;
   logic              we_q;
   logic              gnt0_q, gnt1_q;
   logic              rv0_q, rv1_q;
   logic              rd_q, wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   dmem_arb_pick #(
      .STARVE_LIM (STARVE_LIM),
      .CNT_W      (CNT_W)
   ) u_pick (
      .p0_req_i (p0_req),
      .p1_req_i (p1_req),
      .cnt_i    (starve_q),
      .any_o    (any_d),
      .win1_o   (win1_d),
      .cnt_o    (starve_d)
   );

   // Sequencer: arbitrate in IDLE/RESP, strobe in ISSUE, return data in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         starve_q <= '0;
         win1_q   <= 1'b0;
         we_q     <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         rv0_q  <= 1'b0;
         rv1_q  <= 1'b0;
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (state_q == RESP && !we_q) begin
                  if (win1_q) begin
                     rdata1_q <= mem_rdata;
                     rv1_q    <= 1'b1;
                  end else begin
                     rdata0_q <= mem_rdata;
                     rv0_q    <= 1'b1;
                  end
               end
               if (any_d) begin
                  state_q  <= ISSUE;
                  starve_q <= starve_d;
                  win1_q   <= win1_d;
                  if (win1_d) begin
                     we_q    <= p1_we;
                     addr_q  <= p1_addr;
                     wdata_q <= p1_wdata;
                     wr_q    <= p1_we;
                     rd_q    <= ~p1_we;
                     gnt1_q  <= 1'b1;
                  end else begin
                     we_q    <= p0_we;
                     addr_q  <= p0_addr;
                     wdata_q <= p0_wdata;
                     wr_q    <= p0_we;
                     rd_q    <= ~p0_we;
                     gnt0_q  <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE:   state_q <= RESP;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign p0_gnt    = gnt0_q;
   assign p1_gnt    = gnt1_q;
   assign p0_rvalid = rv0_q;
   assign p1_rvalid = rv1_q;
   assign p0_rdata  = rdata0_q;
   assign p1_rdata  = rdata1_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_read  = rd_q;
   assign mem_write = wr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small memory model:
// reads, writes, starvation order, back-to-back, reset, late request.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       p0_req, p0_we, p1_req, p1_we;
   logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [7:0] p0_rdata, p1_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_write, mem_read;
   logic [7:0] m20 = 8'h00;

   int checks = 0;
   int errors = 0;
   int order[$];
   int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_rdata (mem_rdata)
   );

   // Memory model: 0x10 holds A5, 0x20 is writable; data one cycle after read.
   always @(posedge clk) begin
      if (mem_read)
         mem_rdata <= (mem_addr == 8'h10) ? 8'hA5 :
                      (mem_addr == 8'h20) ? m20 : 8'h00;
      if (mem_write && mem_addr == 8'h20)
         m20 <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
      mem_rdata = 8'h00;
      cyc(2);
      chk("rst_gnt", {30'd0, p0_gnt, p1_gnt}, 0);
      chk("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
      chk("rst_strobes", {30'd0, mem_read, mem_write}, 0);
      chk("rst_addr", {24'd0, mem_addr}, 0);
      chk("rst_rdata", {16'd0, p0_rdata, p1_rdata}, 0);
      chk("rst_state", 32'(dut.state_q), 0);
      rst = 1'b0;

      // p0 read of 0x10
      cyc(1);
      p0_req = 1; p0_we = 0; p0_addr = 8'h10;
      cyc(1);
      chk("rd_gnt", {30'd0, p0_gnt, p1_gnt}, 2);
      chk("rd_strobe", {30'd0, mem_read, mem_write}, 2);
      chk("rd_addr", {24'd0, mem_addr}, 32'h10);
      p0_req = 0;
      cyc(1);
      chk("rd_strobe_one", {30'd0, mem_read, mem_write}, 0);
      chk("rd_early_rv", {31'd0, p0_rvalid}, 0);
      cyc(1);
      chk("rd_rvalid", {31'd0, p0_rvalid}, 1);
      chk("rd_rdata", {24'd0, p0_rdata}, 32'hA5);
      cyc(1);
      chk("rd_rv_pulse", {31'd0, p0_rvalid}, 0);
      chk("rd_rdata_hold", {24'd0, p0_rdata}, 32'hA5);

      // p1 write 0x3C to 0x20
      p1_req = 1; p1_we = 1; p1_addr = 8'h20; p1_wdata = 8'h3C;
      cyc(1);
      chk("wr_gnt", {30'd0, p0_gnt, p1_gnt}, 1);
      chk("wr_strobe", {30'd0, mem_read, mem_write}, 1);
      chk("wr_addr", {24'd0, mem_addr}, 32'h20);
      chk("wr_wdata", {24'd0, mem_wdata}, 32'h3C);
      p1_req = 0;
      cyc(1);
      chk("wr_strobe_one", {30'd0, mem_read, mem_write}, 0);
      cyc(1);
      chk("wr_no_rv", {30'd0, p0_rvalid, p1_rvalid}, 0);
      cyc(1);
      chk("wr_no_rv2", {31'd0, p1_rvalid}, 0);

      // p0 back-to-back reads: grant every other cycle, starve count 0
      p0_req = 1; p0_we = 0; p0_addr = 8'h10;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         chk($sformatf("b2b_gnt%0d", i), {31'd0, p0_gnt}, 32'(i % 2));
         chk($sformatf("b2b_cnt%0d", i), 32'(dut.starve_q), 0);
      end
      p0_req = 0;
      cyc(4);
      chk("b2b_idle", 32'(dut.state_q), 0);

      // both ports continuously: p0 x4 then p1, repeating
      p0_req = 1; p0_we = 0; p0_addr = 8'h10;
      p1_req = 1; p1_we = 0; p1_addr = 8'h20;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (p0_gnt) order.push_back(0);
         if (p1_gnt) order.push_back(1);
      end
      p0_req = 0; p1_req = 0;
      chk("starve_n", 32'(order.size()), 10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("starve_ord%0d", i),
             (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF,
             32'(exp_order[i]));
      end
      cyc(4);
      chk("starve_p1_rdata", {24'd0, p1_rdata}, 32'h3C);

      // reset in RESP of a read
      p0_req = 1; p0_we = 0; p0_addr = 8'h10;
      cyc(1);
      chk("rr_gnt", {31'd0, p0_gnt}, 1);
      p0_req = 0;
      cyc(1);
      rst = 1;
      cyc(1);
      chk("rr_rv", {30'd0, p0_rvalid, p1_rvalid}, 0);
      chk("rr_strobes", {30'd0, mem_read, mem_write}, 0);
      chk("rr_addr", {16'd0, mem_addr, mem_wdata}, 0);
      chk("rr_rdata", {16'd0, p0_rdata, p1_rdata}, 0);
      rst = 0;
      cyc(1);
      chk("rr_no_rv", {31'd0, p0_rvalid}, 0);
      p0_req = 1;
      cyc(1);
      chk("rr2_gnt", {31'd0, p0_gnt}, 1);
      p0_req = 0;
      cyc(2);
      chk("rr2_rv", {31'd0, p0_rvalid}, 1);
      chk("rr2_rdata", {24'd0, p0_rdata}, 32'hA5);

      // p1 request rising while p0 is in ISSUE
      cyc(1);
      p0_req = 1; p0_we = 0; p0_addr = 8'h10;
      cyc(1);
      chk("late_gnt0", {30'd0, p0_gnt, p1_gnt}, 2);
      p0_req = 0;
      p1_req = 1; p1_we = 0; p1_addr = 8'h20;
      cyc(1);
      chk("late_no_gnt", {30'd0, p0_gnt, p1_gnt}, 0);
      cyc(1);
      chk("late_gnt1", {30'd0, p0_gnt, p1_gnt}, 1);
      chk("late_rv0", {31'd0, p0_rvalid}, 1);
      chk("late_addr", {24'd0, mem_addr}, 32'h20);
      p1_req = 0;
      cyc(2);
      chk("late_rv1", {31'd0, p1_rvalid}, 1);
      chk("late_rdata1", {24'd0, p1_rdata}, 32'h3C);

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data-memory word width.
REQ-003 SHALL have parameter STARVE_LIM, default 4, meaning the maximum number of consecutive contended wins by port 0 before port 1 is forced.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have port pN_req (N=0,1), input, 1, a request that is held until pN_gnt.
REQ-007 SHALL have port pN_we, input, 1, where 1=write and 0=read; it is stable while pN_req is high.
REQ-008 SHALL have port pN_addr, input, ADDR_W, the access address; it is stable while pN_req is high.
REQ-009 SHALL have port pN_wdata, input, DATA_W, the write data; it is stable while pN_req is high.
REQ-010 SHALL have port pN_gnt, output, 1, a one-cycle pulse meaning the command was accepted.
REQ-011 SHALL have port pN_rvalid, output, 1, a one-cycle pulse meaning pN_rdata is valid.
REQ-012 SHALL have port pN_rdata, output, DATA_W, the read data; it holds its value until the next read for that port.
REQ-013 SHALL have port mem_addr, output, ADDR_W, the data-memory address.
REQ-014 SHALL have port mem_wdata, output, DATA_W, the data-memory write data.
REQ-015 SHALL have port mem_write, output, 1, the memory write strobe.
REQ-016 SHALL have port mem_read, output, 1, the memory read strobe.
REQ-017 SHALL have port mem_rdata, input, DATA_W, the memory read data; it is valid in the cycle after mem_read.

Function
REQ-018 SHALL implement an FSM with states IDLE, ISSUE and RESP; all outputs SHALL be registered.
REQ-019 SHALL, in IDLE or RESP with a request present, arbitrate: port 0 has priority, except that port 1 wins when starve_cnt==STARVE_LIM.
REQ-020 SHALL, on entering ISSUE, drive mem_addr/mem_wdata from the winner, set mem_write=we or mem_read=!we for exactly one cycle, and pulse the winner's gnt in that same cycle.
REQ-021 SHALL, in RESP, for a read, capture mem_rdata into the winner's pN_rdata and pulse pN_rvalid in the following cycle; a write SHALL produce no rvalid.
REQ-022 SHALL use these transitions: IDLE->ISSUE on any req; ISSUE->RESP always; RESP->ISSUE if any req, else RESP->IDLE.
REQ-023 SHALL give a read latency of req sampled at cycle T -> gnt at T+1 -> rvalid at T+3, and a peak rate of one access per 2 cycles.
REQ-024 SHALL increment starve_cnt when port 0 wins while p1_req=1, reset it to 0 when port 1 wins or p1_req=0, and saturate it at STARVE_LIM.
REQ-025 SHALL strobe mem_read and mem_write only in ISSUE and never both in the same cycle.
REQ-026 SHALL never sample a request during ISSUE; a request that rises during ISSUE SHALL be arbitrated in RESP.
REQ-027 SHALL drop a requester's rvalid when its req falls before gnt; there is no abort after gnt.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, set state to IDLE, starve_cnt to 0, all gnt/rvalid/mem strobes to 0, and mem_addr, mem_wdata and pN_rdata to 0.
REQ-029 SHALL, on a reset asserted mid-access (ISSUE or RESP), discard the access with no rvalid and no further strobes.

Structure
REQ-030 SHALL place the state encoding (IDLE=0, ISSUE=1, RESP=2) and the default widths in the shared processor package.
REQ-031 SHALL use the sub-module dmem_arb_pick (combinational winner select plus starve_cnt update) as the only natural split.

Verification
REQ-032 SHALL cover: reset, then p0 read addr 8'h10 where mem holds 8'hA5 -> p0_gnt at T+1, mem_read one cycle, p0_rvalid with p0_rdata=8'hA5 at T+3.
REQ-033 SHALL cover: p1 write addr 8'h20 data 8'h3C -> mem_write=1 for one cycle with mem_addr 8'h20 and mem_wdata 8'h3C, and no p1_rvalid.
REQ-034 SHALL cover: p0 and p1 requesting continuously with STARVE_LIM=4 -> grant order p0,p0,p0,p0,p1, repeating.
REQ-035 SHALL cover: p0 only, back-to-back reads -> gnt every 2 cycles with starve_cnt staying 0.
REQ-036 SHALL cover: rst asserted in RESP of a read -> no rvalid, all outputs 0 next cycle, and the next req is served normally.
REQ-037 SHALL cover: p1_req rising during ISSUE of a p0 access -> p1 granted from RESP with no idle cycle.
